// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// FftInputLoader (top module fft_input_loader)
//
// Takes a valid/ready stream of packed complex samples and writes one frame
// of N = 2**AWL samples into port A of the FFT sample RAM. The frame-ready
// flag rises at the edge where the final write commits. New input is held
// off until the FFT core acknowledges the frame.
//
// Optional build macro BITREV_ADDR_EN:
//   defined   -> write address is the bit-reverse of the sample count
//   undefined -> write address is the sample count (natural order)
// Timing and handshake behaviour are the same in both builds.
// ---------------------------------------------------------------------------
module fft_input_loader #(
    parameter int DWL = 16,
    parameter int AWL = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           i_VALID,
    output logic           o_READY,
    input  logic [DWL-1:0] i_DATA,
    input  logic           i_LAST,
    output logic           o_RAM_EN,
    output logic           o_RAM_WrE,
    output logic [AWL-1:0] o_RAM_ADDR,
    output logic [DWL-1:0] o_RAM_DATA,
    output logic           o_FRAME_RDY,
    input  logic           i_FRAME_ACK,
    output logic           o_ERR
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [AWL-1:0] LAST_IDX = '1;

    state_t         state_q,    state_d;
    logic [AWL-1:0] count_q,    count_d;
    logic           ramEn_q,    ramEn_d;
    logic [AWL-1:0] ramAddr_q,  ramAddr_d;
    logic [DWL-1:0] ramData_q,  ramData_d;
    logic           frameRdy_q, frameRdy_d;
    logic           err_q,      err_d;

    logic           xfer;
    logic           atLast;

    // Maps a sample index onto its RAM slot for the in-place FFT.
    function automatic logic [AWL-1:0] wrAddr(input logic [AWL-1:0] c);
        logic [AWL-1:0] r;
`ifdef BITREV_ADDR_EN
        for (int b = 0; b < AWL; b++) begin
            r[AWL-1-b] = c[b];
        end
`else
        r = c;
`endif
        return r;
    endfunction

    assign xfer   = i_VALID && (state_q == LOAD);
    assign atLast = (count_q == LAST_IDX);

    // Next-state decode: accept samples in LOAD, spend one cycle draining the
    // last write, then park in FULL until the FFT core acknowledges.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ramEn_d    = 1'b0;
        ramAddr_d  = ramAddr_q;
        ramData_d  = ramData_q;
        frameRdy_d = frameRdy_q;
        err_d      = err_q;

        case (state_q)
            LOAD: begin
                if (xfer) begin
                    count_d   = count_q + 1'b1;
                    ramEn_d   = 1'b1;
                    ramAddr_d = wrAddr(count_q);
                    ramData_d = i_DATA;
                    if (atLast || i_LAST) begin
                        state_d = FLUSH;
                        err_d   = err_q | (i_LAST != atLast);
                    end
                end
            end
            FLUSH: begin
                state_d    = FULL;
                frameRdy_d = 1'b1;
            end
            FULL: begin
                if (i_FRAME_ACK) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    frameRdy_d = 1'b0;
                    err_d      = 1'b0;
                end
            end
            default: begin
                state_d = LOAD;
                count_d = '0;
            end
        endcase
    end

    // State and registered RAM-side outputs; reset drops any partial frame
    // but leaves RAM contents alone.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= LOAD;
            count_q    <= '0;
            ramEn_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramData_q  <= '0;
            frameRdy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ramEn_q    <= ramEn_d;
            ramAddr_q  <= ramAddr_d;
            ramData_q  <= ramData_d;
            frameRdy_q <= frameRdy_d;
            err_q      <= err_d;
        end
    end

    assign o_READY     = (state_q == LOAD);
    assign o_RAM_EN    = ramEn_q;
    assign o_RAM_WrE   = ramEn_q;
    assign o_RAM_ADDR  = ramAddr_q;
    assign o_RAM_DATA  = ramData_q;
    assign o_FRAME_RDY = frameRdy_q;
    assign o_ERR       = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// ---------------------------------------------------------------------------
// Testbench for fft_input_loader with AWL=3 (N=8), DWL=16.
// Expected write addresses follow BITREV_ADDR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fft_input_loader;

    localparam int DWL = 16;
    localparam int AWL = 3;

    logic           CLK;
    logic           RST_N;
    logic           i_VALID;
    logic           o_READY;
    logic [DWL-1:0] i_DATA;
    logic           i_LAST;
    logic           o_RAM_EN;
    logic           o_RAM_WrE;
    logic [AWL-1:0] o_RAM_ADDR;
    logic [DWL-1:0] o_RAM_DATA;
    logic           o_FRAME_RDY;
    logic           i_FRAME_ACK;
    logic           o_ERR;

    int checkCount = 0;
    int errorCount = 0;

    fft_input_loader #(.DWL(DWL), .AWL(AWL)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .i_VALID     (i_VALID),
        .o_READY     (o_READY),
        .i_DATA      (i_DATA),
        .i_LAST      (i_LAST),
        .o_RAM_EN    (o_RAM_EN),
        .o_RAM_WrE   (o_RAM_WrE),
        .o_RAM_ADDR  (o_RAM_ADDR),
        .o_RAM_DATA  (o_RAM_DATA),
        .o_FRAME_RDY (o_FRAME_RDY),
        .i_FRAME_ACK (i_FRAME_ACK),
        .o_ERR       (o_ERR)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected RAM slot for sample index n of an 8-sample frame.
    function automatic logic [2:0] expAddr(input int n);
        logic [2:0] c;
        c = 3'(n);
`ifdef BITREV_ADDR_EN
        return {c[0], c[1], c[2]};
`else
        return c;
`endif
    endfunction

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advances one clock; outputs are then sampled and inputs changed 1 ns later.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    // Checks that nothing is being written this cycle.
    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_en"}, 32'(o_RAM_EN), 32'd0);
        checkOutput({tag, "_wre"}, 32'(o_RAM_WrE), 32'd0);
    endtask

    // Sends one sample with the given data and last flag and checks its write.
    task automatic sendSample(input string tag, input int idx, input logic [15:0] data, input logic last);
        i_VALID = 1'b1;
        i_DATA  = data;
        i_LAST  = last;
        checkOutput({tag, "_ready"}, 32'(o_READY), 32'd1);
        applyStimulus();
        checkOutput({tag, "_en"}, 32'(o_RAM_EN), 32'd1);
        checkOutput({tag, "_wre"}, 32'(o_RAM_WrE), 32'd1);
        checkOutput({tag, "_addr"}, 32'(o_RAM_ADDR), 32'(expAddr(idx)));
        checkOutput({tag, "_data"}, 32'(o_RAM_DATA), 32'(data));
    endtask

    // Checks the FLUSH cycle and the following FULL cycle of a frame.
    task automatic checkFrameEnd(input string tag, input logic expErr);
        checkOutput({tag, "_flush_ready"}, 32'(o_READY), 32'd0);
        checkOutput({tag, "_flush_rdy"}, 32'(o_FRAME_RDY), 32'd0);
        applyStimulus();
        checkOutput({tag, "_full_rdy"}, 32'(o_FRAME_RDY), 32'd1);
        checkOutput({tag, "_full_ready"}, 32'(o_READY), 32'd0);
        checkOutput({tag, "_full_err"}, 32'(o_ERR), 32'(expErr));
        checkIdleBus({tag, "_full"});
    endtask

    // Pulses the frame acknowledge for one edge and checks the return to LOAD.
    task automatic ackFrame(input string tag);
        i_FRAME_ACK = 1'b1;
        applyStimulus();
        i_FRAME_ACK = 1'b0;
        checkOutput({tag, "_ack_rdy"}, 32'(o_FRAME_RDY), 32'd0);
        checkOutput({tag, "_ack_err"}, 32'(o_ERR), 32'd0);
        checkOutput({tag, "_ack_ready"}, 32'(o_READY), 32'd1);
    endtask

    // Directed scenarios.
    initial begin
        RST_N       = 1'b0;
        i_VALID     = 1'b1;
        i_DATA      = 16'h1234;
        i_LAST      = 1'b0;
        i_FRAME_ACK = 1'b0;

        // Reset held three cycles with valid asserted: nothing may be written.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkIdleBus("rst");
            checkOutput("rst_addr", 32'(o_RAM_ADDR), 32'd0);
            checkOutput("rst_data", 32'(o_RAM_DATA), 32'd0);
            checkOutput("rst_rdy", 32'(o_FRAME_RDY), 32'd0);
            checkOutput("rst_err", 32'(o_ERR), 32'd0);
        end
        RST_N   = 1'b1;
        i_VALID = 1'b0;
        checkOutput("post_rst_ready", 32'(o_READY), 32'd1);
        applyStimulus();
        checkIdleBus("post_rst_idle");
        checkOutput("post_rst_ready2", 32'(o_READY), 32'd1);

        // Full frame streamed back to back, LAST on the eighth sample.
        for (int i = 0; i < 8; i++) begin
            sendSample("stream", i, 16'(i), i == 7);
        end
        i_VALID = 1'b1;
        i_DATA  = 16'h00AA;
        i_LAST  = 1'b0;
        checkFrameEnd("stream", 1'b0);

        // Backpressure: valid held in FULL must not produce writes.
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkIdleBus("bp");
            checkOutput("bp_ready", 32'(o_READY), 32'd0);
            checkOutput("bp_rdy", 32'(o_FRAME_RDY), 32'd1);
        end
        ackFrame("bp");
        checkIdleBus("bp_ack");

        // The held sample goes in first, then LAST on the fifth sample.
        sendSample("early", 0, 16'h00AA, 1'b0);
        for (int i = 1; i < 5; i++) begin
            sendSample("early", i, 16'h0010 + 16'(i), i == 4);
        end
        i_VALID = 1'b0;
        i_LAST  = 1'b0;
        checkFrameEnd("early", 1'b1);
        ackFrame("early");

        // Missing LAST, with a stray ACK in LOAD that must be ignored.
        for (int i = 0; i < 8; i++) begin
            i_FRAME_ACK = (i == 1);
            sendSample("nolast", i, 16'hB000 + 16'(i), 1'b0);
        end
        i_FRAME_ACK = 1'b0;
        i_VALID     = 1'b0;
        checkFrameEnd("nolast", 1'b1);
        ackFrame("nolast");

        // Partial frame dropped by a one-cycle reset, then a clean frame.
        for (int i = 0; i < 3; i++) begin
            sendSample("pre_rst", i, 16'hC000 + 16'(i), 1'b0);
        end
        i_VALID = 1'b0;
        RST_N   = 1'b0;
        applyStimulus();
        RST_N = 1'b1;
        checkIdleBus("mid_rst");
        checkOutput("mid_rst_ready", 32'(o_READY), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sendSample("after_rst", i, 16'hD000 + 16'(i), i == 7);
        end
        i_VALID = 1'b0;
        i_LAST  = 1'b0;
        checkFrameEnd("after_rst", 1'b0);

        // Idle cycle with no transfer keeps address and data.
        applyStimulus();
        checkOutput("hold_addr", 32'(o_RAM_ADDR), 32'(expAddr(7)));
        checkOutput("hold_data", 32'(o_RAM_DATA), 32'h0000D007);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
